harmonic_scheduler: RTL and testbench
=====================================

// Module: harmonic_scheduler
// PURPOSE
//  Time-multiplexes one shared sine ROM across three harmonic phase accumulators (1x, 2x, 4x step).
//  Replaces three parallel sine readers per voice.
//  Sits between the note player (generate_next_sample, step_size, weight) and the voice mixer.
//  Fetches only the harmonics the weight needs, accumulates the weighted sum, and emits one sample per request.
// PARAMETERS
//  ROM_LATENCY  1   cycles from rom_addr presented to rom_data valid (legal 1..4)
//  PHASE_W      20  phase accumulator / step_size width
//  ADDR_W       10  ROM address width = phase[PHASE_W-1 -: ADDR_W]
// PORTS
//  clk                   input   1        system clock, all state on rising edge
//  reset                 input   1        asynchronous, active-low (0 = reset)
//  play_enable           input   1        request qualifier
//  generate_next_sample  input   1        1-cycle pulse, next sample request
//  note_done             input   1        request qualifier (1 = note finished)
//  note_start            input   1        1-cycle pulse, zero all phase accumulators
//  step_size             input   PHASE_W  fundamental phase increment
//  weight                input   2        0: H1 only; 1: H1+H2; 2,3: H1+H2+H3
//  rom_addr              output  ADDR_W   address to shared sine ROM
//  rom_data              input   16       signed ROM sample (two's complement)
//  harmonic_out          output  18       signed weighted sample, held until next update
//  sample_ready          output  1        1-cycle pulse, harmonic_out just updated
//  busy                  output  1        1 while a request is in progress (not IDLE)
//  overrun               output  1        sticky, request arrived while busy
// BEHAVIOUR
//  Reset values: phase1..3 = 0; harmonic_out = 0; sample_ready, busy, overrun = 0; rom_addr = 0; state IDLE.
//  Request acceptance
//   - accept = IDLE & generate_next_sample & play_enable & !note_done.
//   - Requests in any other state are dropped and set overrun. Only reset clears overrun.
//  On accept (edge ending cycle T)
//   - Register weight and step_size; later input changes do not affect this sample.
//   - phase1 += S, phase2 += S<<1, phase3 += S<<2, all mod 2^PHASE_W.
//   - Truncate the shifted steps to PHASE_W bits.
//   - All three phases advance every accepted request, whatever the weight.
//   - Clear the accumulator; nh = 1 (w=0), 2 (w=1), 3 (w>=2); k = 1.
//  States: IDLE -> ISSUE -> WAIT -> (ISSUE for the next k | DONE) -> IDLE.
//   - ISSUE (1 cycle): rom_addr = phase_k[PHASE_W-1 -: ADDR_W].
//   - WAIT: hold rom_addr; count ROM_LATENCY-1 cycles.
//   - On the edge where rom_data is valid (ISSUE cycle + ROM_LATENCY), add term_k to the accumulator.
//   - After that edge: k < nh -> ISSUE (k+1); k = nh -> DONE.
//   - rom_addr keeps its last value in IDLE and DONE.
//  Weighted terms (arithmetic shifts on the 16-bit sample, sign-extended to 18 bits, 18-bit sum)
//   - w=0: term1 = x.
//   - w=1: term1 = (x>>>1)+(x>>>3); term2 = (x>>>2)+(x>>>3).
//   - w>=2: term1 = (x>>>1)+(x>>>3); term2 = x>>>2; term3 = x>>>3.
//   - No saturation; the coefficient sums never exceed 1.0, so 18 bits cannot overflow.
//  DONE (1 cycle)
//   - harmonic_out <= accumulator; sample_ready = 1; next state IDLE.
//   - A request in the DONE cycle is dropped (overrun).
//  Latency: sample_ready asserts in cycle T + nh*(ROM_LATENCY+1) + 1.
//   - With ROM_LATENCY=1: T+3 (w=0), T+5 (w=1), T+7 (w>=2).
//  note_start
//   - In IDLE: zero phases at the next edge.
//   - Together with an accepting request: zero first, then add steps, so phase1 = S.
//   - While busy: latch it; apply on the DONE->IDLE edge; the in-flight sample uses the old phases.
//  Qualifier changes mid-sequence
//   - note_done or play_enable dropping after accept does not abort; the sample completes coherently.
//  Asynchronous reset mid-sequence
//   - Returns to IDLE at once with all reset values.
//   - No sample_ready is emitted for the aborted request.
// TESTING
//  1. Reset, then S=0x00400, w=2, ROM stub returns rom_data=addr.
//     -> rom_addr sequence 1, 2, 4; sample_ready at T+7.
//     -> harmonic_out = (0+0)+0+0 = 0; phases 0x00400/0x00800/0x01000.
//  2. ROM constant 16'sh4000, w = 0, 1, 2 in turn -> harmonic_out = 16384 each time.
//     -> Cycle counts T+3, T+5, T+7.
//  3. ROM constant -16384 (16'shC000), w=1 -> harmonic_out = -16384 (18'h3C000).
//     -> w=2 terms are -10240, -4096, -2048.
//  4. Second generate_next_sample at T+2 with w=2.
//     -> Dropped; overrun = 1 and stays 1; exactly one sample_ready.
//  5. note_start pulse at T+3 of a w=2 sequence.
//     -> The current sample uses the old phases; phases = 0 after DONE.
//     -> The next request gives phase1 = S.
//  6. note_done=1 with a generate pulse -> no accept, busy stays 0.
//     -> Reset asserted mid-WAIT: busy=0 and harmonic_out=0 immediately, no sample_ready pulse.

Source files
------------

// File: rtl/harmonic_scheduler.sv
// -----------------------------------------------------------------------------
// harmonic_scheduler
//
// Shares one sine ROM between three harmonic phase accumulators stepping at
// 1x, 2x and 4x the fundamental step. Each accepted request advances all three
// phases, fetches only the harmonics the registered weight needs (one ROM
// access per harmonic, strictly sequential), accumulates the weighted terms
// and emits one 18-bit signed sample together with a one-cycle sample_ready.
//
// Ports
//   clk                   system clock, all state on the rising edge
//   reset                 asynchronous reset, active low
//   play_enable           request qualifier (must be 1 to accept)
//   generate_next_sample  one-cycle request pulse
//   note_done             request qualifier (1 blocks acceptance)
//   note_start            one-cycle pulse, zeroes all phase accumulators
//   step_size             fundamental phase increment
//   weight                0: H1, 1: H1+H2, 2/3: H1+H2+H3
//   rom_addr              shared sine ROM address (registered, held when idle)
//   rom_data              signed ROM sample, ROM_LATENCY cycles after address
//   harmonic_out          signed weighted sample, held until the next update
//   sample_ready          one-cycle pulse, harmonic_out has just been updated
//   busy                  1 while a request is in progress
//   overrun               sticky, a request arrived while busy
// -----------------------------------------------------------------------------
module harmonic_scheduler #(
    parameter int ROM_LATENCY = 1,
    parameter int PHASE_W     = 20,
    parameter int ADDR_W      = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               play_enable,
    input  logic               generate_next_sample,
    input  logic               note_done,
    input  logic               note_start,
    input  logic [PHASE_W-1:0] step_size,
    input  logic [1:0]         weight,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [15:0]        rom_data,
    output logic [17:0]        harmonic_out,
    output logic               sample_ready,
    output logic               busy,
    output logic               overrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // The last WAIT cycle is the one in which rom_data is valid.
    localparam logic [1:0] WAIT_LAST = 2'(ROM_LATENCY - 1);

    // Number of harmonics fetched for a given weight.
    function automatic logic [1:0] harmonic_count(input logic [1:0] w);
        logic [1:0] n;
        case (w)
            2'd0:    n = 2'd1;
            2'd1:    n = 2'd2;
            default: n = 2'd3;
        endcase
        return n;
    endfunction

    // Weighted contribution of harmonic k for sample x. The coefficients per
    // weight sum to at most 1.0, so the 18-bit sum never overflows.
    function automatic logic [17:0] weighted_term(input logic [15:0] x,
                                                  input logic [1:0]  w,
                                                  input logic [1:0]  k);
        logic signed [17:0] xs;
        logic signed [17:0] t;
        xs = {{2{x[15]}}, x};
        t  = 18'sd0;
        case (w)
            2'd0: begin
                t = xs;
            end
            2'd1: begin
                if (k == 2'd1) begin
                    t = (xs >>> 1) + (xs >>> 3);
                end else begin
                    t = (xs >>> 2) + (xs >>> 3);
                end
            end
            default: begin
                case (k)
                    2'd1:    t = (xs >>> 1) + (xs >>> 3);
                    2'd2:    t = xs >>> 2;
                    2'd3:    t = xs >>> 3;
                    default: t = 18'sd0;
                endcase
            end
        endcase
        return t;
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic [PHASE_W-1:0] phase1_r;
    logic [PHASE_W-1:0] phase2_r;
    logic [PHASE_W-1:0] phase3_r;
    logic [PHASE_W-1:0] phase1_next_s;
    logic [PHASE_W-1:0] phase2_next_s;
    logic [PHASE_W-1:0] phase3_next_s;
    logic [PHASE_W-1:0] next_k_phase_s;
    logic [1:0]         weight_r;
    logic [1:0]         nh_r;
    logic [1:0]         k_r;
    logic [1:0]         wait_cnt_r;
    logic [17:0]        acc_r;
    logic [17:0]        term_s;
    logic [17:0]        acc_sum_s;
    logic               zero_pend_r;
    logic               accept_s;
    logic               data_valid_s;
    logic               last_k_s;
    logic [ADDR_W-1:0]  rom_addr_r;
    logic [17:0]        harmonic_out_r;
    logic               sample_ready_r;
    logic               busy_r;
    logic               overrun_r;

    assign rom_addr     = rom_addr_r;
    assign harmonic_out = harmonic_out_r;
    assign sample_ready = sample_ready_r;
    assign busy         = busy_r;
    assign overrun      = overrun_r;

    // Request qualification, ROM-data timing and next-state decode.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        data_valid_s = 1'b0;
        last_k_s     = 1'b0;
        if (state_r == ST_IDLE) begin
            accept_s = generate_next_sample & play_enable & ~note_done;
        end else begin
            accept_s = 1'b0;
        end
        if ((state_r == ST_WAIT) && (wait_cnt_r == WAIT_LAST)) begin
            data_valid_s = 1'b1;
        end else begin
            data_valid_s = 1'b0;
        end
        last_k_s = (k_r == nh_r);
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (!data_valid_s) begin
                    state_next_s = ST_WAIT;
                end else if (last_k_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Phase values produced by an accepting edge: a coincident note_start
    // zeroes first, then the 1x/2x/4x steps are added (shifts truncate).
    always_comb begin
        phase1_next_s = {PHASE_W{1'b0}};
        phase2_next_s = {PHASE_W{1'b0}};
        phase3_next_s = {PHASE_W{1'b0}};
        if (note_start) begin
            phase1_next_s = step_size;
            phase2_next_s = {step_size[PHASE_W-2:0], 1'b0};
            phase3_next_s = {step_size[PHASE_W-3:0], 2'b00};
        end else begin
            phase1_next_s = phase1_r + step_size;
            phase2_next_s = phase2_r + {step_size[PHASE_W-2:0], 1'b0};
            phase3_next_s = phase3_r + {step_size[PHASE_W-3:0], 2'b00};
        end
    end

    // Phase of the harmonic fetched after the current one (k+1 is 2 or 3).
    always_comb begin
        next_k_phase_s = phase2_r;
        case (k_r)
            2'd1:    next_k_phase_s = phase2_r;
            default: next_k_phase_s = phase3_r;
        endcase
    end

    // Weighted term for the ROM word arriving this cycle and running sum.
    always_comb begin
        term_s    = weighted_term(rom_data, weight_r, k_r);
        acc_sum_s = acc_r + term_s;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Phase accumulators. A note_start seen while busy is deferred to the
    // DONE->IDLE edge so the in-flight sample keeps its phases.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase1_r    <= {PHASE_W{1'b0}};
            phase2_r    <= {PHASE_W{1'b0}};
            phase3_r    <= {PHASE_W{1'b0}};
            zero_pend_r <= 1'b0;
        end else if (accept_s) begin
            phase1_r    <= phase1_next_s;
            phase2_r    <= phase2_next_s;
            phase3_r    <= phase3_next_s;
            zero_pend_r <= 1'b0;
        end else if (((state_r == ST_IDLE) && note_start) ||
                     ((state_r == ST_DONE) && (note_start || zero_pend_r))) begin
            phase1_r    <= {PHASE_W{1'b0}};
            phase2_r    <= {PHASE_W{1'b0}};
            phase3_r    <= {PHASE_W{1'b0}};
            zero_pend_r <= 1'b0;
        end else if (note_start) begin
            zero_pend_r <= 1'b1;
        end else begin
            zero_pend_r <= zero_pend_r;
        end
    end

    // Sequencing datapath: captured weight, harmonic index, ROM wait counter,
    // ROM address and the running accumulator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            weight_r   <= 2'd0;
            nh_r       <= 2'd1;
            k_r        <= 2'd1;
            wait_cnt_r <= 2'd0;
            acc_r      <= 18'd0;
            rom_addr_r <= {ADDR_W{1'b0}};
        end else if (accept_s) begin
            weight_r   <= weight;
            nh_r       <= harmonic_count(weight);
            k_r        <= 2'd1;
            wait_cnt_r <= 2'd0;
            acc_r      <= 18'd0;
            rom_addr_r <= phase1_next_s[PHASE_W-1 -: ADDR_W];
        end else if (state_r == ST_ISSUE) begin
            wait_cnt_r <= 2'd0;
        end else if (data_valid_s) begin
            acc_r <= acc_sum_s;
            if (!last_k_s) begin
                k_r        <= k_r + 2'd1;
                rom_addr_r <= next_k_phase_s[PHASE_W-1 -: ADDR_W];
            end else begin
                k_r <= k_r;
            end
        end else if (state_r == ST_WAIT) begin
            wait_cnt_r <= wait_cnt_r + 2'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Registered outputs: sample and its strobe land on the edge entering
    // DONE, so both are visible during the DONE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            harmonic_out_r <= 18'd0;
            sample_ready_r <= 1'b0;
            busy_r         <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            if (data_valid_s && last_k_s) begin
                harmonic_out_r <= acc_sum_s;
                sample_ready_r <= 1'b1;
            end else begin
                sample_ready_r <= 1'b0;
            end
            busy_r    <= (state_next_s != ST_IDLE);
            overrun_r <= overrun_r | (generate_next_sample & (state_r != ST_IDLE));
        end
    end

endmodule

// File: tb/tb_harmonic_scheduler.sv
// -----------------------------------------------------------------------------
// tb_harmonic_scheduler
//
// Randomized self-checking bench. A one-cycle-latency ROM stub feeds the DUT;
// a reference model tracks the three phases arithmetically, derives the
// expected ROM addresses, the weighted sum and the sample latency, and checks
// overrun and note_start behaviour.
// -----------------------------------------------------------------------------
module tb_harmonic_scheduler;

    logic        clk;
    logic        reset;
    logic        play_enable;
    logic        generate_next_sample;
    logic        note_done;
    logic        note_start;
    logic [19:0] step_size;
    logic [1:0]  weight;
    logic [9:0]  rom_addr;
    logic [15:0] rom_data;
    logic [17:0] harmonic_out;
    logic        sample_ready;
    logic        busy;
    logic        overrun;

    logic [15:0] rom_mem [0:1023];
    logic        rom_mode;
    logic [15:0] rom_const;

    logic [19:0] p1, p2, p3;
    logic        exp_ovr;
    int          n_checks;
    int          n_pass;

    harmonic_scheduler dut (
        .clk                  (clk),
        .reset                (reset),
        .play_enable          (play_enable),
        .generate_next_sample (generate_next_sample),
        .note_done            (note_done),
        .note_start           (note_start),
        .step_size            (step_size),
        .weight               (weight),
        .rom_addr             (rom_addr),
        .rom_data             (rom_data),
        .harmonic_out         (harmonic_out),
        .sample_ready         (sample_ready),
        .busy                 (busy),
        .overrun              (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM stub with one cycle of latency.
    always @(posedge clk) begin
        rom_data <= rom_mode ? rom_const : rom_mem[rom_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    endtask

    function automatic int rom_value(input logic [9:0] a);
        logic [15:0] v;
        v = rom_mode ? rom_const : rom_mem[a];
        return int'($signed(v));
    endfunction

    // One request issued at a negedge (cycle T); gen_at / ns_at inject an
    // extra request or a note_start pulse in cycle T+gen_at / T+ns_at.
    task automatic run_request(input logic [19:0] s, input logic [1:0] w,
                               input bit ns_with, input int gen_at, input int ns_at);
        int          nh, lat, pulses, x, sum;
        logic [9:0]  a [1:3];
        logic [17:0] exp_out;
        bit          zero_after;
        if (ns_with) begin
            p1 = 20'd0; p2 = 20'd0; p3 = 20'd0;
        end
        p1 = p1 + s;
        p2 = p2 + (s << 1);
        p3 = p3 + (s << 2);
        a[1] = p1[19:10];
        a[2] = p2[19:10];
        a[3] = p3[19:10];
        nh  = (w == 2'd0) ? 1 : ((w == 2'd1) ? 2 : 3);
        lat = nh * 2 + 1;
        sum = 0;
        for (int k = 1; k <= nh; k++) begin
            x = rom_value(a[k]);
            if (w == 2'd0) sum += x;
            else if (w == 2'd1) sum += (k == 1) ? (x >>> 1) + (x >>> 3) : (x >>> 2) + (x >>> 3);
            else sum += (k == 1) ? (x >>> 1) + (x >>> 3) : ((k == 2) ? (x >>> 2) : (x >>> 3));
        end
        exp_out    = 18'(sum);
        zero_after = 1'b0;
        pulses     = 0;

        generate_next_sample = 1'b1;
        play_enable          = 1'b1;
        note_done            = 1'b0;
        step_size            = s;
        weight               = w;
        note_start           = ns_with;
        for (int j = 1; j <= lat + 2; j++) begin
            @(negedge clk);
            generate_next_sample = 1'b0;
            note_start           = 1'b0;
            if (j == 1) begin
                step_size = 20'($urandom);
                weight    = 2'($urandom);
                chk("busy_high", 32'(busy), 32'd1);
                if (gen_at == 0) begin
                    play_enable = 1'($urandom);
                    note_done   = 1'($urandom);
                end
            end
            if ((j % 2 == 1) && (j <= 2 * nh - 1))
                chk("rom_addr", 32'(rom_addr), 32'(a[(j + 1) / 2]));
            if (sample_ready) begin
                pulses++;
                chk("latency", 32'(j), 32'(lat));
                chk("harmonic_out", 32'(harmonic_out), 32'(exp_out));
            end
            if (j == gen_at) begin
                generate_next_sample = 1'b1;
                play_enable          = 1'b1;
                note_done            = 1'b0;
                exp_ovr              = 1'b1;
            end
            if (j == ns_at) begin
                note_start = 1'b1;
                zero_after = 1'b1;
            end
        end
        chk("one_pulse", 32'(pulses), 32'd1);
        chk("busy_low", 32'(busy), 32'd0);
        chk("overrun", 32'(overrun), 32'(exp_ovr));
        if (zero_after) begin
            p1 = 20'd0; p2 = 20'd0; p3 = 20'd0;
        end
        play_enable = 1'b1;
        note_done   = 1'b0;
    endtask

    initial begin
        int nh_r, gat, nat;
        logic [1:0] wr;
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b0;
        play_enable = 1'b0;
        generate_next_sample = 1'b0;
        note_done = 1'b0;
        note_start = 1'b0;
        step_size = 20'd0;
        weight = 2'd0;
        rom_mode = 1'b0;
        rom_const = 16'd0;
        p1 = 20'd0; p2 = 20'd0; p3 = 20'd0;
        exp_ovr = 1'b0;
        for (int i = 0; i < 1024; i++) rom_mem[i] = 16'(i);

        repeat (2) @(negedge clk);
        chk("rst_harmonic_out", 32'(harmonic_out), 32'd0);
        chk("rst_sample_ready", 32'(sample_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Address-echo ROM: addresses 1, 2, 4, sum 0.
        run_request(20'h00400, 2'd2, 1'b0, 0, 0);

        // Constant +0.5 ROM at every weight.
        rom_mode  = 1'b1;
        rom_const = 16'h4000;
        for (int w = 0; w < 3; w++) run_request(20'h01234, 2'(w), 1'b0, 0, 0);

        // Constant -0.5 ROM.
        rom_const = 16'hC000;
        run_request(20'h02345, 2'd1, 1'b0, 0, 0);
        run_request(20'h03456, 2'd2, 1'b0, 0, 0);

        // Request while busy, then note_start while busy.
        rom_mode = 1'b0;
        for (int i = 0; i < 1024; i++) rom_mem[i] = 16'($urandom);
        run_request(20'h0ABCD, 2'd2, 1'b0, 2, 0);
        run_request(20'h11111, 2'd2, 1'b0, 0, 3);
        run_request(20'h05000, 2'd0, 1'b0, 0, 0);

        // Randomized requests.
        for (int n = 0; n < 30; n++) begin
            wr   = 2'($urandom);
            nh_r = (wr == 2'd0) ? 1 : ((wr == 2'd1) ? 2 : 3);
            gat  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * nh_r + 1) : 0;
            nat  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * nh_r + 1) : 0;
            run_request(20'($urandom), wr, 1'($urandom), gat, nat);
        end

        // note_done blocks acceptance.
        generate_next_sample = 1'b1;
        note_done = 1'b1;
        @(negedge clk);
        generate_next_sample = 1'b0;
        note_done = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("nd_busy", 32'(busy), 32'd0);
            chk("nd_ready", 32'(sample_ready), 32'd0);
            @(negedge clk);
        end

        // note_start alone in IDLE zeroes the phases.
        note_start = 1'b1;
        @(negedge clk);
        note_start = 1'b0;
        p1 = 20'd0; p2 = 20'd0; p3 = 20'd0;
        run_request(20'h0C801, 2'd1, 1'b0, 0, 0);

        // Reset in the middle of a WAIT cycle.
        generate_next_sample = 1'b1;
        play_enable = 1'b1;
        step_size = 20'h3F000;
        weight = 2'd2;
        @(negedge clk);
        generate_next_sample = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_harmonic_out", 32'(harmonic_out), 32'd0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        chk("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("mid_rst_ready", 32'(sample_ready), 32'd0);
        end
        reset = 1'b1;
        p1 = 20'd0; p2 = 20'd0; p3 = 20'd0;
        exp_ovr = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk("post_rst_ready", 32'(sample_ready), 32'd0);
        end
        run_request(20'h0FACE, 2'd2, 1'b0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
